rolfmobile99_in_cond: RTL and testbench



---
 rtl/rolfmobile99_in_cond.sv | 123 ++++++++++++
 tb/tb_rolfmobile99_in_cond.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rolfmobile99_in_cond.sv
// Two-channel input conditioner: synchronise, debounce and edge-detect a_raw/b_raw ahead of the XNOR stage.
// Optional accepted-change counter on evt_cnt is enabled by defining IN_COND_EVTCNT_EN.
module rolfmobile99_in_cond #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_raw,
  input  logic       b_raw,
  output logic       a_clean,
  output logic       b_clean,
  output logic       a_chg,
  output logic       b_chg,
  output logic       busy
`ifdef IN_COND_EVTCNT_EN
  ,
  output logic [7:0] evt_cnt
`endif
);

  localparam logic [0:0]       ST_STABLE  = 1'b0;
  localparam logic [0:0]       ST_PENDING = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q  [2];
  logic [SYNC_STAGES-1:0] sync_d  [2];
  logic [0:0]             state_q [2];
  logic [0:0]             state_d [2];
  logic [CNT_W-1:0]       cnt_q   [2];
  logic [CNT_W-1:0]       cnt_d   [2];
  logic [1:0]             clean_q, clean_d;
  logic [1:0]             chg_q, chg_d;

  assign raw = {b_raw, a_raw};

  // Index 0 is channel A, index 1 is channel B; both channels run the same debounce FSM.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      sync_d[ch]  = {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      clean_d[ch] = clean_q[ch];
      chg_d[ch]   = 1'b0;
      case (state_q[ch])
        ST_STABLE: begin
          if (sync_q[ch][SYNC_STAGES-1] != clean_q[ch]) begin
            state_d[ch] = ST_PENDING;
            cnt_d[ch]   = CNT_W'(1);
          end else begin
            cnt_d[ch] = '0;
          end
        end
        ST_PENDING: begin
          // A return to the clean level is a glitch and takes priority over acceptance.
          if (sync_q[ch][SYNC_STAGES-1] == clean_q[ch]) begin
            state_d[ch] = ST_STABLE;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = ST_STABLE;
            cnt_d[ch]   = '0;
            clean_d[ch] = sync_q[ch][SYNC_STAGES-1];
            chg_d[ch]   = 1'b1;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
          end
        end
        default: begin
          state_d[ch] = ST_STABLE;
          cnt_d[ch]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch]  <= '0;
        state_q[ch] <= ST_STABLE;
        cnt_q[ch]   <= '0;
      end
      clean_q <= '0;
      chg_q   <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch]  <= sync_d[ch];
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      clean_q <= clean_d;
      chg_q   <= chg_d;
    end
  end

  assign a_clean = clean_q[0];
  assign b_clean = clean_q[1];
  assign a_chg   = chg_q[0];
  assign b_chg   = chg_q[1];
  assign busy    = (state_q[0] == ST_PENDING) || (state_q[1] == ST_PENDING);

`ifdef IN_COND_EVTCNT_EN
  logic [7:0] evt_cnt_q, evt_cnt_d;

  // Counts on the acceptance itself, so evt_cnt steps on the same edge the strobes rise.
  always_comb begin
    evt_cnt_d = evt_cnt_q + 8'(chg_d[0]) + 8'(chg_d[1]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_cnt_q <= '0;
    end else begin
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign evt_cnt = evt_cnt_q;
`endif

endmodule

// File: tb/tb_rolfmobile99_in_cond.sv
// Directed bench for rolfmobile99_in_cond: table of held input levels with expected outputs, plus reset and wrap sequences.
// Define IN_COND_EVTCNT_EN to also check the evt_cnt counter.
module tb_rolfmobile99_in_cond;

  logic clk;
  logic reset;
  logic a_raw;
  logic b_raw;
  logic a_clean;
  logic b_clean;
  logic a_chg;
  logic b_chg;
  logic busy;
`ifdef IN_COND_EVTCNT_EN
  logic [7:0] evt_cnt;
  logic [7:0] exp_evt;
`endif

  int total = 0;
  int bad   = 0;

  // exp bit order: {a_clean, b_clean, a_chg, b_chg, busy}
  typedef struct {
    logic       a;
    logic       b;
    int         edges;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  rolfmobile99_in_cond #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(8),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a_raw(a_raw),
    .b_raw(b_raw),
    .a_clean(a_clean),
    .b_clean(b_clean),
    .a_chg(a_chg),
    .b_chg(b_chg),
    .busy(busy)
`ifdef IN_COND_EVTCNT_EN
    ,
    .evt_cnt(evt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge before sampling.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic a, input logic b, input int edges);
    a_raw = a;
    b_raw = b;
    cyc(edges);
  endtask

  task automatic checkOutput(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {a_clean, b_clean, a_chg, b_chg, busy};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: {a_clean,b_clean,a_chg,b_chg,busy} got %b want %b", name, act, exp);
    end
  endtask

`ifdef IN_COND_EVTCNT_EN
  task automatic checkEvt(input string name, input logic [7:0] exp);
    total++;
    if (evt_cnt !== exp) begin
      bad++;
      $display("[TB] FAIL %s: evt_cnt got %0d want %0d", name, evt_cnt, exp);
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    a_raw = 1'b1;
    b_raw = 1'b1;
`ifdef IN_COND_EVTCNT_EN
    exp_evt = 8'd0;
`endif

    for (int i = 0; i < 5; i++) begin
      cyc(1);
      checkOutput($sformatf("reset_hold_%0d", i), 5'b00000);
`ifdef IN_COND_EVTCNT_EN
      checkEvt($sformatf("reset_hold_evt_%0d", i), 8'd0);
`endif
    end
    a_raw = 1'b0;
    b_raw = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(3);
    checkOutput("post_release_idle", 5'b00000);

    vecs.push_back('{1'b1, 1'b0, 2,  5'b00000, "rise_sync_delay"});
    vecs.push_back('{1'b1, 1'b0, 1,  5'b00001, "rise_busy_edge3"});
    vecs.push_back('{1'b1, 1'b0, 6,  5'b00001, "rise_busy_edge9"});
    vecs.push_back('{1'b1, 1'b0, 1,  5'b10100, "rise_accept_edge10"});
    vecs.push_back('{1'b1, 1'b0, 1,  5'b10000, "rise_strobe_drop"});
    vecs.push_back('{1'b0, 1'b0, 9,  5'b10001, "fall_busy_edge9"});
    vecs.push_back('{1'b0, 1'b0, 1,  5'b00100, "fall_accept"});
    vecs.push_back('{1'b0, 1'b0, 1,  5'b00000, "fall_settle"});
    vecs.push_back('{1'b1, 1'b0, 6,  5'b00001, "glitch6_high"});
    vecs.push_back('{1'b0, 1'b0, 2,  5'b00001, "glitch6_tail"});
    vecs.push_back('{1'b0, 1'b0, 1,  5'b00000, "glitch6_abort"});
    vecs.push_back('{1'b0, 1'b0, 10, 5'b00000, "glitch6_no_change"});
    vecs.push_back('{1'b1, 1'b0, 7,  5'b00001, "glitch7_high"});
    vecs.push_back('{1'b0, 1'b0, 2,  5'b00001, "glitch7_tail"});
    vecs.push_back('{1'b0, 1'b0, 1,  5'b00000, "glitch7_abort"});
    vecs.push_back('{1'b1, 1'b0, 8,  5'b00001, "pulse8_high"});
    vecs.push_back('{1'b0, 1'b0, 1,  5'b00001, "pulse8_last_count"});
    vecs.push_back('{1'b0, 1'b0, 1,  5'b10100, "pulse8_accept"});
    vecs.push_back('{1'b0, 1'b0, 1,  5'b10001, "pulse8_fall_pending"});
    vecs.push_back('{1'b0, 1'b0, 6,  5'b10001, "pulse8_fall_busy"});
    vecs.push_back('{1'b0, 1'b0, 1,  5'b00100, "pulse8_fall_accept"});
    vecs.push_back('{1'b0, 1'b0, 1,  5'b00000, "pulse8_settle"});
    vecs.push_back('{1'b1, 1'b1, 9,  5'b00001, "simul_busy"});
    vecs.push_back('{1'b1, 1'b1, 1,  5'b11110, "simul_accept"});
    vecs.push_back('{1'b1, 1'b1, 1,  5'b11000, "simul_settle"});
    vecs.push_back('{1'b0, 1'b0, 9,  5'b11001, "simul_fall_busy"});
    vecs.push_back('{1'b0, 1'b0, 1,  5'b00110, "simul_fall_accept"});
    vecs.push_back('{1'b0, 1'b0, 1,  5'b00000, "simul_fall_settle"});
    vecs.push_back('{1'b0, 1'b1, 10, 5'b01010, "b_rise_accept"});
    vecs.push_back('{1'b0, 1'b0, 10, 5'b00010, "b_fall_accept"});
    vecs.push_back('{1'b0, 1'b0, 1,  5'b00000, "b_settle"});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].edges);
      checkOutput(vecs[i].name, vecs[i].exp);
`ifdef IN_COND_EVTCNT_EN
      exp_evt = exp_evt + 8'(vecs[i].exp[2]) + 8'(vecs[i].exp[1]);
      checkEvt({vecs[i].name, "_evt"}, exp_evt);
`endif
    end

    // Reset during PENDING must discard the partial qualification.
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("rstmid_pending", 5'b00001);
    reset = 1'b0;
    #1;
    checkOutput("rstmid_async_clear", 5'b00000);
`ifdef IN_COND_EVTCNT_EN
    exp_evt = 8'd0;
    checkEvt("rstmid_evt_clear", exp_evt);
`endif
    cyc(2);
    reset = 1'b1;
    cyc(9);
    checkOutput("rstmid_requalify_edge9", 5'b00001);
    cyc(1);
    checkOutput("rstmid_accept_edge10", 5'b10100);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("rstmid_fall_accept", 5'b00100);
`ifdef IN_COND_EVTCNT_EN
    checkEvt("rstmid_evt", 8'd2);
`endif
    cyc(1);

`ifdef IN_COND_EVTCNT_EN
    reset = 1'b0;
    a_raw = 1'b0;
    b_raw = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(2);
    checkEvt("wrap_start", 8'd0);
    for (int i = 0; i < 255; i++) applyStimulus(~a_raw, b_raw, 20);
    checkEvt("wrap_reach_255", 8'd255);
    applyStimulus(~a_raw, b_raw, 20);
    checkEvt("wrap_plus1", 8'd0);
    for (int i = 0; i < 255; i++) applyStimulus(~a_raw, b_raw, 20);
    checkEvt("wrap_reach_255_again", 8'd255);
    applyStimulus(~a_raw, ~b_raw, 10);
    checkOutput("wrap_simul_strobes", 5'b01110);
    checkEvt("wrap_plus2", 8'd1);
    cyc(10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
